aes_cmd_sched: RTL
==================

# aes_cmd_sched

Command sequencer in front of the AES core (`aes_top`). It accepts one command at a time (SET_KEY or ENCRYPT) on a valid/ready slave port and issues it to the core as a single-cycle `en` pulse. It waits for the core's `en_o` completion, with a watchdog timeout, and returns the result plus a status code on a valid/ready master port. It tracks whether a key schedule is loaded and rejects ENCRYPT until one is.

## Interface
Parameters:
- TIMEOUT, 64: cycles in WAIT without `core_en_o` before the command is aborted with timeout status; legal range 2..65535.

Ports:
- clk  in  1  single clock; all logic on the rising edge
- reset  in  1  synchronous, active-low reset
- s_valid  in  1  command valid
- s_ready  out  1  command accepted when both `s_valid` and `s_ready` are high
- s_cmd  in  `WORD_S`  opcode; `SET_KEY` and `ENCRYPT` are legal
- s_key  in  `KEY_S`  key; used by SET_KEY only
- s_data  in  `BLK_S`  plaintext; used by ENCRYPT only
- m_valid  out  1  response valid
- m_ready  in  1  response accepted
- m_data  out  `BLK_S`  ciphertext for ENCRYPT ok; 0 otherwise
- m_status  out  2  00 ok, 01 no key loaded, 10 timeout, 11 illegal opcode
- core_en  out  1  one-cycle start pulse to the core
- core_cmd  out  `WORD_S`  to core `aes_cmd`
- core_key  out  `KEY_S`  to core `aes_key`
- core_plaintext  out  `BLK_S`  to core `aes_plaintext`
- core_ciphertext  in  `BLK_S`  from core `aes_ciphertext`
- core_en_o  in  1  core completion pulse
- key_loaded  out  1  a complete key schedule is resident
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: `s_ready`=1. On handshake, latch `s_cmd`, `s_key` and `s_data` into the command registers, then branch:
  - opcode neither `SET_KEY` nor `ENCRYPT`: go to RESP, status 11, m_data 0.
  - `ENCRYPT` while `key_loaded`=0: go to RESP, status 01, m_data 0.
  - otherwise: go to ISSUE.
- ISSUE: `core_en`=1 for exactly this cycle. If the command is SET_KEY, clear `key_loaded` (the schedule is being overwritten). Next state WAIT; clear the watchdog counter.
- WAIT:
  - `core_cmd`/`core_key`/`core_plaintext` stay driven from the latched registers through ISSUE and WAIT.
  - The counter increments each cycle.
  - On `core_en_o`=1 with SET_KEY: set `key_loaded`, status 00, m_data 0, go to RESP.
  - On `core_en_o`=1 with ENCRYPT: capture `core_ciphertext` into m_data, status 00, go to RESP.
  - If the counter equals TIMEOUT-1 and `core_en_o`=0: status 10, m_data 0, go to RESP. A timed-out SET_KEY leaves `key_loaded`=0.
  - `core_en_o` and timeout in the same cycle: completion wins.
- RESP: `m_valid`=1; `m_data`/`m_status` held stable until `m_ready`. On handshake go to IDLE. `s_ready`=0.
- `core_en_o` outside WAIT (stray or late) is ignored and changes no state.
- Watchdog counter width is clog2(TIMEOUT); it never wraps because it is cleared in ISSUE and used only in WAIT.
- Core outputs are zero in IDLE and RESP. `core_en` is never asserted outside ISSUE.

## Timing
- Reset (`reset`=0 at an edge) forces: state IDLE, `s_ready`=0 during reset, `m_valid`=0, `m_data`=0, `m_status`=00, `core_en`=0, `core_cmd`/`core_key`/`core_plaintext`=0, `key_loaded`=0, `busy`=0, counter 0. In the first cycle after release `s_ready`=1.
- Reset mid-operation (ISSUE/WAIT/RESP): the command is dropped with no response, `key_loaded` is cleared, and the next cycle is IDLE.
- Accepted command at edge t:
  - `core_en`=1 during cycle t+1.
  - WAIT starts at t+2.
- Error path: `m_valid` rises in cycle t+1.
- `core_en_o` seen at edge w (in WAIT): `m_valid`=1 from cycle w+1.
- Timeout: WAIT entered at cycle c; if there is no `core_en_o` through cycle c+TIMEOUT-1, `m_valid`=1 at cycle c+TIMEOUT.
- Response accepted at edge r: IDLE at r+1, with `s_ready`=1 in that cycle.
- Minimum command-to-command spacing is 4 cycles plus core latency.
- `m_valid` is never deasserted without a handshake.

## Test plan
- After reset, ENCRYPT with s_data=0x00112233445566778899aabbccddeeff -> one response, `m_status`=01, `m_data`=0, `core_en` never pulses.
- SET_KEY with key 0x000102030405060708090a0b0c0d0e0f, then ENCRYPT with that plaintext -> two responses with status 00; the second has `m_data`=0x69c4e0d86a7b0430d8cdb78070b4c55a; `key_loaded`=1 after the first response.
- Opcode 0xdeadbeef -> status 11 one cycle after acceptance; `key_loaded` unchanged; no `core_en`.
- TIMEOUT=8 with a core model that never asserts `core_en_o` -> `m_valid` exactly 8 cycles after WAIT entry, status 10; for SET_KEY, `key_loaded`=0 afterwards.
- `m_ready` held low for 5 cycles in RESP -> `m_data`/`m_status` stable, `s_ready`=0, and a stray `core_en_o` is ignored.
- `reset` asserted in WAIT, then an ENCRYPT is sent -> no response for the aborted command, and the new ENCRYPT returns status 01.

Source files
------------

// File: rtl/aes_cmd_sched.sv
// aes_cmd_sched: one-at-a-time SET_KEY/ENCRYPT sequencer in front of the AES core, with a watchdog
// Ports:
//   i_clk, i_reset (sync, active-low)
//   i_s_valid/o_s_ready, i_s_cmd/i_s_key/i_s_data  command slave port
//   o_m_valid/i_m_ready, o_m_data/o_m_status        response master port (00 ok, 01 no key, 10 timeout, 11 bad opcode)
//   o_core_en/o_core_cmd/o_core_key/o_core_plaintext, i_core_ciphertext/i_core_en_o  core side
//   o_key_loaded, o_busy                            status
module aes_cmd_sched #(
    parameter int TIMEOUT = 64,
    parameter int WORD_W = 32,
    parameter int KEY_W = 128,
    parameter int BLK_W = 128,
    parameter logic [WORD_W-1:0] SET_KEY = 1,
    parameter logic [WORD_W-1:0] ENCRYPT = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_s_valid,
    output logic              o_s_ready,
    input  logic [WORD_W-1:0] i_s_cmd,
    input  logic [KEY_W-1:0]  i_s_key,
    input  logic [BLK_W-1:0]  i_s_data,
    output logic              o_m_valid,
    input  logic              i_m_ready,
    output logic [BLK_W-1:0]  o_m_data,
    output logic [1:0]        o_m_status,
    output logic              o_core_en,
    output logic [WORD_W-1:0] o_core_cmd,
    output logic [KEY_W-1:0]  o_core_key,
    output logic [BLK_W-1:0]  o_core_plaintext,
    input  logic [BLK_W-1:0]  i_core_ciphertext,
    input  logic              i_core_en_o,
    output logic              o_key_loaded,
    output logic              o_busy
);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            r_state;
    logic [WORD_W-1:0] r_cmd;
    logic [KEY_W-1:0]  r_key;
    logic [BLK_W-1:0]  r_data;
    logic [CW-1:0]     r_cnt;
    logic [BLK_W-1:0]  r_m_data;
    logic [1:0]        r_m_status;
    logic              r_key_loaded;
    logic              w_act;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state      <= IDLE;
            r_cmd        <= '0;
            r_key        <= '0;
            r_data       <= '0;
            r_cnt        <= '0;
            r_m_data     <= '0;
            r_m_status   <= 2'b00;
            r_key_loaded <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (i_s_valid) begin
                    r_cmd  <= i_s_cmd;
                    r_key  <= i_s_key;
                    r_data <= i_s_data;
                    if (i_s_cmd != SET_KEY && i_s_cmd != ENCRYPT) begin
                        r_state    <= RESP;
                        r_m_status <= 2'b11;
                    end else if (i_s_cmd == ENCRYPT && !r_key_loaded) begin
                        r_state    <= RESP;
                        r_m_status <= 2'b01;
                    end else
                        r_state <= ISSUE;
                end
                ISSUE: begin
                    // the resident schedule is being overwritten from this point on
                    if (r_cmd == SET_KEY)
                        r_key_loaded <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    // completion takes priority over a coincident timeout
                    if (i_core_en_o) begin
                        r_state    <= RESP;
                        r_m_status <= 2'b00;
                        if (r_cmd == SET_KEY)
                            r_key_loaded <= 1'b1;
                        else
                            r_m_data <= i_core_ciphertext;
                    end else if (r_cnt == LAST) begin
                        r_state    <= RESP;
                        r_m_status <= 2'b10;
                    end
                end
                RESP: if (i_m_ready) begin
                    r_state    <= IDLE;
                    r_m_data   <= '0;
                    r_m_status <= 2'b00;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_act            = r_state == ISSUE || r_state == WAIT;
    assign o_s_ready        = i_reset && r_state == IDLE;
    assign o_m_valid        = r_state == RESP;
    assign o_m_data         = r_m_data;
    assign o_m_status       = r_m_status;
    assign o_core_en        = r_state == ISSUE;
    assign o_core_cmd       = w_act ? r_cmd : '0;
    assign o_core_key       = w_act ? r_key : '0;
    assign o_core_plaintext = w_act ? r_data : '0;
    assign o_key_loaded     = r_key_loaded;
    assign o_busy           = r_state != IDLE;
endmodule
